alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0, meaning 0 = round-robin arbitration, 1 = fixed priority with requester 0 always winning.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_x, req0_y  input  16 each  requester 0 operands.
REQ-007 req0_ctl  input  6  requester 0 ALU control, bit order {zx,nx,zy,ny,f,no}, bit 5 = zx.
REQ-008 req1_valid, req1_ready, req1_x, req1_y, req1_ctl: same widths and meanings for requester 1.
REQ-009 alu_x, alu_y  output  16 each  operands driven to the shared ALU.
REQ-010 alu_ctl  output  6  control driven to the shared ALU, same bit order as REQ-007.
REQ-011 alu_out  input  16  combinational ALU result; alu_zr, alu_ng  input  1 each  ALU zero and negative flags.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_id  output  1  index of the requester that owns the result.
REQ-015 rsp_out  output  16; rsp_zr, rsp_ng  output  1 each  registered ALU result and flags.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-018 In IDLE, if any reqN_valid is high, the block SHALL grant exactly one requester and assert that reqN_ready combinationally in the same cycle.
REQ-019 On the grant edge, the block SHALL latch the granted x, y and ctl into the registers driving alu_x, alu_y and alu_ctl, latch rsp_id, and move to EXEC.
REQ-020 reqN_ready SHALL be 0 outside IDLE and 0 for the non-granted requester.
REQ-021 In EXEC, held for exactly 1 cycle, the block SHALL register alu_out, alu_zr and alu_ng into rsp_out, rsp_zr and rsp_ng, then move to RESP.
REQ-022 In RESP, rsp_valid SHALL be 1; when rsp_ready is 1 at the edge, the block SHALL move to IDLE.
REQ-023 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-024 rsp_out, rsp_zr, rsp_ng and rsp_id SHALL hold their values until the next EXEC capture.
REQ-025 alu_x, alu_y and alu_ctl SHALL stay stable from the grant edge until the next grant.
REQ-026 Minimum latency SHALL be: accept at cycle N, rsp_valid high at N+2; throughput is at most one operation per 3 cycles.
REQ-027 Round-robin rule (PRIO_MODE=0): a last_grant bit records the last winner.
REQ-028 With both requesters valid, the requester not equal to last_grant SHALL win.
REQ-029 With one requester valid, that requester SHALL win regardless of last_grant.
REQ-030 last_grant SHALL update only on a grant.
REQ-031 Fixed rule (PRIO_MODE=1): with both requesters valid, requester 0 SHALL win.
REQ-032 A reqN_valid asserted during EXEC or RESP SHALL NOT be accepted until the FSM returns to IDLE.
REQ-033 If rsp_ready is already high on entry to RESP, the block SHALL complete the handshake in the first RESP cycle.
REQ-034 A requester SHALL hold valid and its operands until ready; the arbiter does not sample the operands at any other time.

Reset
REQ-035 While rst is high, the block SHALL force: state=IDLE, last_grant=1 so that requester 0 wins first, alu_x=0, alu_y=0, alu_ctl=0, rsp_out=0, rsp_zr=0, rsp_ng=0, rsp_id=0.
REQ-036 While rst is high, rsp_valid, busy, req0_ready and req1_ready SHALL be 0.
REQ-037 Reset asserted during EXEC or RESP SHALL discard the in-flight operation; no rsp_valid SHALL appear for it after reset is released.

Verification
REQ-038 The bench SHALL use a real ALU instance connected to alu_* and cover the following scenarios.
REQ-039 req0 x=5, y=7, ctl=000010 -> req0_ready 1 in cycle 0; rsp_valid 1 in cycle 2 with rsp_out=12, zr=0, ng=0, rsp_id=0.
REQ-040 req1 x=3, y=5, ctl=010011 (x-y) -> rsp_out=0xFFFE, ng=1, zr=0, rsp_id=1; ctl=101010 -> rsp_out=0, zr=1, ng=0.
REQ-041 Both requesters valid continuously, PRIO_MODE=0, from reset -> grant order 0,1,0,1; PRIO_MODE=1 -> grant order 0,0,0.
REQ-042 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_out stay stable, both reqN_ready stay 0, busy=1; rsp_ready=1 -> IDLE the next cycle.
REQ-043 rst pulsed while in EXEC -> all outputs at their REQ-035/REQ-036 values, rsp_valid never asserts for the discarded operation, and the next request completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
//
// Each operation runs through IDLE -> EXEC -> RESP. In IDLE one requester is
// granted and its operands are latched onto the ALU. In EXEC the ALU result is
// registered. In RESP the result is held until the consumer accepts it.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   reqN_valid / reqN_ready      request handshake for requester N (0, 1)
//   reqN_x, reqN_y, reqN_ctl     requester N operands and ALU control {zx,nx,zy,ny,f,no}
//   alu_x, alu_y, alu_ctl        registered operands driven to the shared ALU
//   alu_out, alu_zr, alu_ng      combinational ALU result and flags
//   rsp_valid / rsp_ready        response handshake
//   rsp_id, rsp_out, rsp_zr/ng   owner of the result, registered result and flags
//   busy                         high whenever the FSM is not idle
//
// PRIO_MODE: 0 = round-robin, 1 = fixed priority with requester 0 winning.
module alu_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_x,
    input  logic [15:0] req0_y,
    input  logic [5:0]  req0_ctl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_x,
    input  logic [15:0] req1_y,
    input  logic [5:0]  req1_ctl,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_ctl,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_out,
    output logic        rsp_zr,
    output logic        rsp_ng,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_last_grant;
    logic [15:0] r_alu_x;
    logic [15:0] r_alu_y;
    logic [5:0]  r_alu_ctl;
    logic [15:0] r_rsp_out;
    logic        r_rsp_zr;
    logic        r_rsp_ng;
    logic        r_rsp_id;

    logic        w_any;
    logic        w_pick1;
    logic        w_grant;

    // Arbitration: w_pick1 selects requester 1 as the winner.
    always_comb begin
        w_any   = req0_valid | req1_valid;
        w_pick1 = 1'b0;
        if (req0_valid && req1_valid) begin
            // Round-robin hands the grant to whoever did not win last time.
            w_pick1 = (PRIO_MODE == 0) ? ~r_last_grant : 1'b0;
        end else begin
            w_pick1 = req1_valid;
        end
        // Gated by rst so ready stays low for the whole reset pulse.
        w_grant    = (r_state == StIdle) && w_any && !rst;
        req0_ready = w_grant && !w_pick1;
        req1_ready = w_grant && w_pick1;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_any) w_state_next = StExec;
            StExec: w_state_next = StResp;
            StResp: if (rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_alu_x      <= '0;
            r_alu_y      <= '0;
            r_alu_ctl    <= '0;
            r_rsp_out    <= '0;
            r_rsp_zr     <= 1'b0;
            r_rsp_ng     <= 1'b0;
            r_rsp_id     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last_grant <= w_pick1;
                r_rsp_id     <= w_pick1;
                r_alu_x      <= w_pick1 ? req1_x   : req0_x;
                r_alu_y      <= w_pick1 ? req1_y   : req0_y;
                r_alu_ctl    <= w_pick1 ? req1_ctl : req0_ctl;
            end
            if (r_state == StExec) begin
                r_rsp_out <= alu_out;
                r_rsp_zr  <= alu_zr;
                r_rsp_ng  <= alu_ng;
            end
        end
    end

    assign alu_x     = r_alu_x;
    assign alu_y     = r_alu_y;
    assign alu_ctl   = r_alu_ctl;
    assign rsp_out   = r_rsp_out;
    assign rsp_zr    = r_rsp_zr;
    assign rsp_ng    = r_rsp_ng;
    assign rsp_id    = r_rsp_id;
    assign rsp_valid = (r_state == StResp);
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vectors, scoreboard queues popped by a
// response monitor. dut0 runs round-robin, dut1 runs fixed priority.
module tb_alu_arbiter;

    typedef struct packed {
        logic        id;
        logic [15:0] out;
        logic        zr;
        logic        ng;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic [5:0]  req0_ctl, req1_ctl;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_ctl;
    logic        alu_zr, alu_ng;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zr, rsp_ng, busy;
    logic [15:0] rsp_out;

    logic        p_req0_valid, p_req0_ready, p_req1_valid, p_req1_ready;
    logic [15:0] p_alu_x, p_alu_y, p_alu_out;
    logic [5:0]  p_alu_ctl;
    logic        p_alu_zr, p_alu_ng;
    logic        p_rsp_valid, p_rsp_ready, p_rsp_id, p_rsp_zr, p_rsp_ng, p_busy;
    logic [15:0] p_rsp_out;

    rsp_t q0[$];
    rsp_t q1[$];
    rsp_t m_exp0, m_exp1;
    int   n_cmp = 0;
    int   n_err = 0;

    // Hack-style ALU; returns {ng, zr, out}.
    function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] ctl);
        logic [15:0] a, b, o;
        a = ctl[5] ? 16'h0 : x;
        a = ctl[4] ? ~a : a;
        b = ctl[3] ? 16'h0 : y;
        b = ctl[2] ? ~b : b;
        o = ctl[1] ? (a + b) : (a & b);
        o = ctl[0] ? ~o : o;
        return {o[15], (o == 16'h0), o};
    endfunction

    always_comb {alu_ng, alu_zr, alu_out} = hack_alu(alu_x, alu_y, alu_ctl);
    always_comb {p_alu_ng, p_alu_zr, p_alu_out} = hack_alu(p_alu_x, p_alu_y, p_alu_ctl);

    alu_arbiter #(.PRIO_MODE(0)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_ctl(req0_ctl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_ctl(req1_ctl),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .busy(busy)
    );

    alu_arbiter #(.PRIO_MODE(1)) u_dut_prio (
        .clk(clk), .rst(rst),
        .req0_valid(p_req0_valid), .req0_ready(p_req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_ctl(req0_ctl),
        .req1_valid(p_req1_valid), .req1_ready(p_req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_ctl(req1_ctl),
        .alu_x(p_alu_x), .alu_y(p_alu_y), .alu_ctl(p_alu_ctl),
        .alu_out(p_alu_out), .alu_zr(p_alu_zr), .alu_ng(p_alu_ng),
        .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready), .rsp_id(p_rsp_id),
        .rsp_out(p_rsp_out), .rsp_zr(p_rsp_zr), .rsp_ng(p_rsp_ng), .busy(p_busy)
    );

    function automatic rsp_t mk(input logic id, input logic [15:0] out, input logic zr,
                                input logic ng);
        rsp_t r;
        r.id  = id;
        r.out = out;
        r.zr  = zr;
        r.ng  = ng;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every accepted response.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rr_unexpected_rsp: got id=%0d out=%0h expected none",
                         rsp_id, rsp_out);
            end else begin
                m_exp0 = q0.pop_front();
                check("rr_rsp{id,out,zr,ng}", {13'b0, rsp_id, rsp_out, rsp_zr, rsp_ng},
                      {13'b0, m_exp0});
            end
        end
        if (p_rsp_valid && p_rsp_ready) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL prio_unexpected_rsp: got id=%0d out=%0h expected none",
                         p_rsp_id, p_rsp_out);
            end else begin
                m_exp1 = q1.pop_front();
                check("prio_rsp{id,out,zr,ng}",
                      {13'b0, p_rsp_id, p_rsp_out, p_rsp_zr, p_rsp_ng}, {13'b0, m_exp1});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_idle_timeout: got busy=1 expected 0", name);
        end
    endtask

    // Presents one operation, waits for its grant, then drops valid.
    task automatic issue_op(input logic id, input logic [15:0] x, input logic [15:0] y,
                            input logic [5:0] ctl, input logic [15:0] eo, input logic ez,
                            input logic en);
        int k = 0;
        tick();
        if (id) begin
            req1_x = x; req1_y = y; req1_ctl = ctl; req1_valid = 1'b1;
        end else begin
            req0_x = x; req0_y = y; req0_ctl = ctl; req0_valid = 1'b1;
        end
        q0.push_back(mk(id, eo, ez, en));
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!(id ? req1_ready : req0_ready)) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_timeout: got ready=0 expected 1 for req%0d", id);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int k;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req0_ctl = '0;
        req1_x = '0; req1_y = '0; req1_ctl = '0;
        p_req0_valid = 1'b0; p_req1_valid = 1'b0;
        rsp_ready = 1'b1;
        p_rsp_ready = 1'b1;
        #2 rst = 1'b1;

        // Reset values, with both requesters asking.
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_x", alu_x, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        // Basic add with cycle-exact latency.
        tick();
        req0_x = 16'd5; req0_y = 16'd7; req0_ctl = 6'b000010; req0_valid = 1'b1;
        q0.push_back(mk(1'b0, 16'd12, 1'b0, 1'b0));
        @(negedge clk);
        check("c0_req0_ready", req0_ready, 1);
        check("c0_req1_ready", req1_ready, 0);
        check("c0_rsp_valid", rsp_valid, 0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("c1_busy", busy, 1);
        check("c1_rsp_valid", rsp_valid, 0);
        check("c1_alu_ops", {alu_ctl, alu_x}, {6'b000010, 16'd5});
        check("c1_alu_y", alu_y, 7);
        @(negedge clk);
        check("c2_rsp_valid", rsp_valid, 1);
        @(negedge clk);
        check("c3_busy", busy, 0);

        // Requester 1 vectors.
        issue_op(1'b1, 16'd3, 16'd5, 6'b010011, 16'hFFFE, 1'b0, 1'b1);
        wait_idle("sub");
        issue_op(1'b1, 16'd3, 16'd5, 6'b101010, 16'h0000, 1'b1, 1'b0);
        wait_idle("zero");
        issue_op(1'b0, 16'hF0F0, 16'hFF00, 6'b000000, 16'hF000, 1'b0, 1'b1);
        wait_idle("and");

        // Round-robin from reset: 0,1,0,1.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        req0_x = 16'd1;  req0_y = 16'd2;  req0_ctl = 6'b000010;
        req1_x = 16'd10; req1_y = 16'd20; req1_ctl = 6'b000010;
        q0.push_back(mk(1'b0, 16'd3, 1'b0, 1'b0));
        q0.push_back(mk(1'b1, 16'd30, 1'b0, 1'b0));
        q0.push_back(mk(1'b0, 16'd3, 1'b0, 1'b0));
        q0.push_back(mk(1'b1, 16'd30, 1'b0, 1'b0));
        req0_valid = 1'b1; req1_valid = 1'b1;
        g = 0; k = 0;
        while (g < 4 && k < 40) begin
            @(negedge clk);
            if (req0_ready || req1_ready) g++;
            k++;
        end
        check("rr_grant_count", g, 4);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("rr");

        // Fixed priority: 0,0,0.
        q1.push_back(mk(1'b0, 16'd3, 1'b0, 1'b0));
        q1.push_back(mk(1'b0, 16'd3, 1'b0, 1'b0));
        q1.push_back(mk(1'b0, 16'd3, 1'b0, 1'b0));
        tick();
        p_req0_valid = 1'b1; p_req1_valid = 1'b1;
        g = 0; k = 0;
        while (g < 3 && k < 40) begin
            @(negedge clk);
            if (p_req0_ready || p_req1_ready) g++;
            k++;
        end
        check("prio_grant_count", g, 3);
        tick();
        p_req0_valid = 1'b0; p_req1_valid = 1'b0;
        k = 0;
        while (p_busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("prio_idle", p_busy, 0);

        // Consumer stall for 5 cycles in RESP with both requesters asking.
        rsp_ready = 1'b0;
        issue_op(1'b0, 16'd100, 16'd23, 6'b000010, 16'd123, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("stall_rsp_valid0", rsp_valid, 1);
        tick();
        req0_x = 16'd7; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_out", rsp_out, 123);
            check("stall_readies", {req0_ready, req1_ready}, 0);
            check("stall_busy", busy, 1);
            check("stall_alu_x", alu_x, 100);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_stall_busy", busy, 0);
        check("post_stall_rsp_valid", rsp_valid, 0);
        check("post_stall_hold_out", rsp_out, 123);

        // Reset while in EXEC discards the operation.
        tick();
        req1_x = 16'd7; req1_y = 16'd9; req1_ctl = 6'b000010; req1_valid = 1'b1;
        @(negedge clk);
        check("abort_grant", req1_ready, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_alu", {alu_ctl, alu_x, alu_y}, 0);
        check("abort_rsp", {rsp_id, rsp_out, rsp_zr, rsp_ng}, 0);
        check("abort_readies", {req0_ready, req1_ready}, 0);
        tick();
        req1_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
        end
        issue_op(1'b0, 16'hFFFF, 16'd1, 6'b000010, 16'h0000, 1'b1, 1'b0);
        wait_idle("after_abort");

        tick();
        check("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
